// File: rtl/mem_line_responder_if.sv
// Line-wide memory bus shared by line initiators (caches, ring couplers)
// and line responders. One request outstanding at a time.
interface mem_if #(
  parameter int LINE_BYTES = 64
) ();
  logic [31:0]             addr;
  logic [8*LINE_BYTES-1:0] data_i;
  logic [LINE_BYTES-1:0]   data_en;
  logic                    read_en;
  logic                    write_en;
  logic [8*LINE_BYTES-1:0] data_o;
  logic                    hit;
  logic                    done;

  modport initiator (
    output addr, data_i, data_en, read_en, write_en,
    input  data_o, hit, done
  );

  modport responder (
    input  addr, data_i, data_en, read_en, write_en,
    output data_o, hit, done
  );
endinterface

// File: rtl/mem_line_responder.sv
// Line-granular backing store answering mem_if requests with programmable
// read/write latency. On reset every line is swept with a pattern where each
// 32-bit word holds its own byte address, so readers can check data without
// preloading.
module mem_line_responder #(
  parameter int LINE_BYTES    = 64,
  parameter int NUM_LINES     = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_if.responder    mem,
  output logic        init_done,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int WORDS  = LINE_BYTES / 4;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESPOND} state_t;

  state_t r_state;
  state_t w_state_next;

  // Sweep index is one bit wider so it can reach NUM_LINES (sweep finished).
  logic [IDX_W:0]      r_init_idx;
  logic [15:0]         r_lat_cnt;

  // Latched request
  logic [IDX_W-1:0]    r_idx;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_BYTES-1:0] r_wmask;
  logic                r_is_write;

  // Storage and its registered read port
  logic [LINE_W-1:0]   r_ram [NUM_LINES];
  logic [LINE_W-1:0]   r_rd_line;

  // Registered outputs
  logic                r_hit;
  logic [LINE_W-1:0]   r_data_o;
  logic                r_init_done;
  logic [31:0]         r_read_count;
  logic [31:0]         r_write_count;

  logic                w_req;
  logic [IDX_W-1:0]    w_req_idx;
  logic [15:0]         w_req_lat;
  logic                w_sweep_active;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [LINE_W-1:0]   w_init_line;
  logic [LINE_W-1:0]   w_merged;
  logic                w_ram_we;
  logic [IDX_W-1:0]    w_ram_waddr;
  logic [LINE_W-1:0]   w_ram_wdata;
  logic                w_unused_addr;

  assign w_req     = mem.read_en | mem.write_en;
  assign w_req_idx = mem.addr[OFF_W+IDX_W-1:OFF_W];
  // Both enables high means write.
  assign w_req_lat = mem.write_en ? 16'(WRITE_LATENCY) : 16'(READ_LATENCY);
  assign w_sweep_active = (r_state == S_INIT) && (r_init_idx != (IDX_W+1)'(NUM_LINES));
  // While idle the read port follows the incoming address so the line is
  // already available when READ_LATENCY is 1.
  assign w_rd_idx  = (r_state == S_IDLE) ? w_req_idx : r_idx;

  // Offset bits and aliasing high bits take no part in addressing.
  assign w_unused_addr = ^{mem.addr[31:OFF_W+IDX_W], mem.addr[OFF_W-1:0]};

  // Power-on pattern for the line under the sweep pointer, and the
  // byte-masked merge of the latched write data onto the stored line.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_init_word
      assign w_init_line[32*gi +: 32] =
        32'({r_init_idx[IDX_W-1:0], {OFF_W{1'b0}}}) + 32'(4 * gi);
    end
    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_merge_byte
      assign w_merged[8*gi +: 8] = (r_is_write && r_wmask[gi]) ?
                                   r_wdata[8*gi +: 8] : r_rd_line[8*gi +: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT: begin
        if (!w_sweep_active) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (w_req) w_state_next = (w_req_lat == 16'd1) ? S_RESPOND : S_BUSY;
      end
      S_BUSY: begin
        if (!w_req)                  w_state_next = S_IDLE;
        else if (r_lat_cnt == 16'd2) w_state_next = S_RESPOND;
      end
      S_RESPOND: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_INIT;
    endcase
  end

  // Storage write port selection: sweep lines during INIT, merged line on a
  // write response. Nothing is written while reset is held.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_idx;
    w_ram_wdata = w_merged;
    if (!reset) begin
      if (w_sweep_active) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_init_idx[IDX_W-1:0];
        w_ram_wdata = w_init_line;
      end else if (r_state == S_RESPOND && r_is_write) begin
        w_ram_we    = 1'b1;
      end
    end
  end

  // Line storage write
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
  end

  // Registered storage read
  always_ff @(posedge clk) begin
    r_rd_line <= r_ram[w_rd_idx];
  end

  // Latch the request on acceptance
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_req) begin
      r_idx      <= w_req_idx;
      r_wdata    <= mem.data_i;
      r_wmask    <= mem.data_en;
      r_is_write <= mem.write_en;
    end
  end

  // Sweep pointer, latency counter, response outputs and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_idx    <= '0;
      r_lat_cnt     <= '0;
      r_hit         <= 1'b0;
      r_data_o      <= '0;
      r_init_done   <= 1'b0;
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      if (w_sweep_active) r_init_idx <= r_init_idx + 1'b1;
      if (r_state == S_INIT && !w_sweep_active) r_init_done <= 1'b1;

      if (r_state == S_IDLE && w_req) r_lat_cnt <= w_req_lat;
      else if (r_state == S_BUSY)     r_lat_cnt <= r_lat_cnt - 16'd1;

      r_hit <= (r_state == S_RESPOND);
      if (r_state == S_RESPOND) begin
        r_data_o <= w_merged;
        if (r_is_write) r_write_count <= r_write_count + 32'd1;
        else            r_read_count  <= r_read_count + 32'd1;
      end
    end
  end

  assign mem.data_o  = r_data_o;
  assign mem.hit     = r_hit;
  assign mem.done    = r_hit;
  assign init_done   = r_init_done;
  assign read_count  = r_read_count;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: init sweep timing, read/write
// latency, byte masking, aliasing, abandonment and reset during a request.
module tb_mem_line_responder;

  localparam int LB = 64;
  localparam int NL = 256;
  localparam int RL = 4;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done;
  logic [31:0] read_count;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_pass   = 0;

  mem_if #(.LINE_BYTES(LB)) mif ();

  mem_line_responder #(
    .LINE_BYTES(LB), .NUM_LINES(NL), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset(reset), .mem(mif),
    .init_done(init_done), .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // All driving and sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pattern_line(input logic [31:0] base);
    logic [511:0] l;
    for (int w = 0; w < LB/4; w++) l[32*w +: 32] = base + 32'(4*w);
    return l;
  endfunction

  // Issue one request, hold it until hit, then drop it during the hit cycle.
  task automatic do_req(input string name, input logic [31:0] a, input logic [511:0] d,
                        input logic [63:0] m, input logic rd, input logic wr,
                        input int exp_lat, input logic [511:0] exp_line);
    int n;
    logic [511:0] seen;
    n = 0;
    mif.addr = a; mif.data_i = d; mif.data_en = m;
    mif.read_en = rd; mif.write_en = wr;
    tick();  // acceptance edge
    do begin
      tick();
      n++;
    end while (mif.hit !== 1'b1 && n < 20);
    check({name, "_lat"}, 512'(n), 512'(exp_lat));
    check({name, "_done"}, 512'(mif.done), 512'(1));
    check({name, "_data"}, mif.data_o, exp_line);
    seen = mif.data_o;
    mif.read_en = 1'b0; mif.write_en = 1'b0;
    tick();
    check({name, "_hit_pulse"}, 512'(mif.hit), 512'(0));
    check({name, "_data_hold"}, mif.data_o, seen);
    $display("txn %s addr=%h rd=%0b wr=%0b lat=%0d word0=%h rc=%0d wc=%0d",
             name, a, rd, wr, n, seen[31:0], read_count, write_count);
  endtask

  // Release reset and measure cycles until init_done; hits during INIT counted.
  task automatic wait_init(input string name);
    int n;
    int early_hits;
    n = 0;
    early_hits = 0;
    reset = 1'b0;
    do begin
      tick();
      n++;
      if (mif.hit === 1'b1) early_hits++;
    end while (init_done !== 1'b1 && n < NL + 20);
    // n-th tick after release is edge e0+(n-1)
    check({name, "_init_lat"}, 512'(n - 1), 512'(NL));
    check({name, "_init_hits"}, 512'(early_hits), 512'(0));
    $display("txn %s init cycles=%0d", name, n - 1);
  endtask

  logic [511:0] wline;
  logic [511:0] exp_line;

  initial begin
    mif.addr = '0; mif.data_i = '0; mif.data_en = '0;
    mif.read_en = 1'b0; mif.write_en = 1'b0;

    repeat (3) tick();
    check("rst_hit", 512'(mif.hit), 512'(0));
    check("rst_done", 512'(mif.done), 512'(0));
    check("rst_data", mif.data_o, 512'(0));
    check("rst_init_done", 512'(init_done), 512'(0));
    check("rst_counts", 512'({read_count, write_count}), 512'(0));

    wait_init("boot");

    // Plain read of line 1
    do_req("rd40", 32'h40, '0, '0, 1'b1, 1'b0, RL, pattern_line(32'h40));
    check("rd40_rc", 512'(read_count), 512'(1));

    // Masked write of word0 of line 2; other bytes of data_i are poison
    wline = {128{4'hA}};
    wline[31:0] = 32'hDEADBEEF;
    exp_line = pattern_line(32'h80);
    exp_line[31:0] = 32'hDEADBEEF;
    do_req("wr80", 32'h80, wline, 64'h000F, 1'b0, 1'b1, WL, exp_line);
    check("wr80_wc", 512'(write_count), 512'(1));
    check("wr80_rc", 512'(read_count), 512'(1));

    do_req("rd80", 32'h80, '0, '0, 1'b1, 1'b0, RL, exp_line);

    // Address beyond NUM_LINES aliases onto line 2
    do_req("rd_alias", 32'h80 + NL*LB, '0, '0, 1'b1, 1'b0, RL, exp_line);
    check("alias_rc", 512'(read_count), 512'(3));

    // Both enables high: a write; empty mask leaves the line untouched
    do_req("wr_nomask", 32'hC0, {16{32'h12345678}}, 64'h0, 1'b1, 1'b1, WL, pattern_line(32'hC0));
    check("nomask_wc", 512'(write_count), 512'(2));
    check("nomask_rc", 512'(read_count), 512'(3));

    // Offset bits inside the line are ignored
    do_req("rd_offset", 32'h10C5, '0, '0, 1'b1, 1'b0, RL, pattern_line(32'h10C0));

    // Abandoned read: enable held for two edges then dropped
    begin
      int hits;
      hits = 0;
      mif.addr = 32'h100; mif.read_en = 1'b1;
      tick();
      tick();
      mif.read_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (mif.hit === 1'b1) hits++;
      end
      check("abandon_hits", 512'(hits), 512'(0));
      check("abandon_counts", 512'({read_count, write_count}), 512'({32'd4, 32'd2}));
      $display("txn abandon addr=00000100 hits=%0d rc=%0d wc=%0d", hits, read_count, write_count);
    end

    // Reset during BUSY of a read to the written line, read held through INIT
    begin
      int n;
      mif.addr = 32'h80; mif.read_en = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      check("midrst_hit", 512'(mif.hit), 512'(0));
      check("midrst_init_done", 512'(init_done), 512'(0));
      check("midrst_counts", 512'({read_count, write_count}), 512'(0));
      wait_init("reboot");
      n = 0;
      do begin
        tick();
        n++;
      end while (mif.hit !== 1'b1 && n < 20);
      // IDLE from e0+NL, accepted at e0+NL+1, hit at e0+NL+1+RL
      check("pending_lat", 512'(n), 512'(RL + 1));
      check("pending_data", mif.data_o, pattern_line(32'h80));
      mif.read_en = 1'b0;
      tick();
      check("pending_rc", 512'(read_count), 512'(1));
      check("pending_wc", 512'(write_count), 512'(0));
      $display("txn pending_rd addr=00000080 lat=%0d word0=%h rc=%0d", n, mif.data_o[31:0], read_count);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Synthesizable cache-line memory server that answers requests on the long (`LINE_BYTES`-wide) `mem_if`: the responder end of the line protocol that caches and `ring_to_mem` couplers drive as initiators. It replaces the long-to-short coupler plus word RAM in ring and cache benches, and serves as a simple line-granular backing store. It provides programmable read/write latency and a deterministic power-on pattern (every 32-bit word equals its own byte address), so benches can check read data without preloading.

## Interface
- `LINE_BYTES`, `CACHE_LINE_BYTES`: bytes per line; power of two, at least 4.
- `NUM_LINES`, 256: lines stored; power of two.
- `READ_LATENCY`, 4: cycles from request acceptance to `hit`; at least 1.
- `WRITE_LATENCY`, 2: cycles from request acceptance to `hit` for writes; at least 1.

Ports (clock and reset first):
- `clk` input 1: sole clock; all logic samples on its rising edge.
- `reset` input 1: synchronous, active-high.
- `mem` mem_if #(`LINE_BYTES`) responder: the initiator drives `addr`[31:0], `data_i`[8*LINE_BYTES-1:0], `data_en`[LINE_BYTES-1:0] (byte write mask), `read_en` and `write_en`. The block drives `data_o`[8*LINE_BYTES-1:0], `hit` and `done`.
- `init_done` output 1: high once the power-on pattern sweep has completed.
- `read_count` output 32: number of reads completed.
- `write_count` output 32: number of writes completed.

## Operation
- Line index is `addr`[log2(LINE_BYTES)+log2(NUM_LINES)-1 : log2(LINE_BYTES)].
  - Offset bits are ignored.
  - Higher address bits alias, so the index wraps modulo `NUM_LINES`.
- States: INIT, IDLE, BUSY, RESPOND.
- INIT (entered on reset):
  - Writes one line per cycle, for lines 0..NUM_LINES-1.
  - Word w of line i is written with i*LINE_BYTES + 4*w.
  - After the last line, `init_done` goes to 1 and the state goes to IDLE.
  - Requests are ignored and not latched; `hit` stays 0.
- IDLE: on a rising edge with `read_en` or `write_en` high, latch `addr`, `data_i`, `data_en` and the kind, load the latency counter, and go to BUSY.
- Kind selection:
  - If both enables are high, the request is a write.
  - A write with `data_en`=0 still completes and counts as a write, but modifies nothing.
- BUSY:
  - The counter decrements each cycle.
  - When it reaches 1, go to RESPOND.
  - If both `read_en` and `write_en` are sampled low during BUSY, the request is abandoned: go to IDLE with no write, no `hit`, and no count change.
- RESPOND (exactly one cycle):
  - `hit`=`done`=1 and `data_o` = the line contents.
  - For writes, bytes whose `data_en` bit is set are replaced by the latched `data_i`, and `data_o` shows the post-write line.
  - The matching counter increments; counters wrap at 2^32.
  - Next state is IDLE.
- The initiator must drop or change its enables during the RESPOND cycle. A request still asserted at the next IDLE edge is treated as a new request.
- `data_o` holds its last RESPOND value until the next RESPOND.

## Timing
- Reset values: `hit`=0, `done`=0, `data_o`=0, `init_done`=0, `read_count`=0, `write_count`=0; state = INIT with sweep index 0.
- Reset asserted mid-operation:
  - Any in-flight request is discarded.
  - Storage is re-initialized by a full INIT sweep; prior writes are lost.
- `init_done` rises NUM_LINES cycles after the edge at which reset is sampled low.
- Read latency:
  - Request sampled at edge k; `hit` is high between edges k+READ_LATENCY and k+READ_LATENCY+1.
  - With READ_LATENCY=1, BUSY is skipped and the block goes straight from IDLE to RESPOND.
- Writes follow the same rule with WRITE_LATENCY.
- Throughput: at most one request per latency+1 cycles. There is no pipelining and only one request is outstanding.
- `hit` and `done` are registered outputs: no combinational path from any input.

## Test plan
- Reset, then wait for `init_done`. `init_done` must rise exactly NUM_LINES cycles after reset is released, and never before.
- Read `addr`=0x40 with LINE_BYTES=64. `hit` must be high for exactly one cycle, 4 cycles after acceptance, and `data_o` words must be 0x40, 0x44, ..., 0x7C. `read_count` becomes 1.
- Write `addr`=0x80 with `data_en`=0x000F and `data_i` low word 0xDEADBEEF; then read 0x80.
  - The write's `hit` comes 2 cycles after acceptance.
  - The read returns word0=0xDEADBEEF and word1=0x84 (unchanged).
  - `write_count` becomes 1.
- Alias and abandonment:
  - Read `addr`=0x80+NUM_LINES*LINE_BYTES. It must return the same line as 0x80.
  - Assert `read_en`, then drop it after 2 cycles. No `hit` occurs and counts are unchanged.
- Assert reset during BUSY, and separately assert `read_en` throughout INIT.
  - No `hit` may occur until `init_done`=1.
  - The pending read is then served with the initialization pattern; earlier writes are gone.
